// File: rtl/branch_update_arbiter.sv
// Two-pipe round-robin arbiter feeding an in-order FIFO that drains into the predictor jump-update port.
// Optional MIST1032ISA_BRANCH_UPDATE_BYPASS_EN: empty-FIFO grants load the output registers directly.
module branch_update_arbiter #(
  parameter int unsigned P_DEPTH   = 4,
  parameter int unsigned P_DEPTH_N = 2
) (
  input  logic                 iCLOCK,
  input  logic                 iRESET,
  input  logic                 iFLUSH,
  input  logic                 iREQ0_VALID,
  input  logic                 iREQ0_HIT,
  input  logic [31:0]          iREQ0_ADDR,
  input  logic [31:0]          iREQ0_INST_ADDR,
  output logic                 oREQ0_READY,
  input  logic                 iREQ1_VALID,
  input  logic                 iREQ1_HIT,
  input  logic [31:0]          iREQ1_ADDR,
  input  logic [31:0]          iREQ1_INST_ADDR,
  output logic                 oREQ1_READY,
  input  logic                 iHOLD,
  output logic                 oJUMP_STB,
  output logic                 oJUMP_HIT,
  output logic [31:0]          oJUMP_ADDR,
  output logic [31:0]          oJUMP_INST_ADDR,
  output logic [P_DEPTH_N:0]   oCOUNT,
  output logic                 oEMPTY,
  output logic                 oFULL
);

  typedef struct packed {
    logic        hit;
    logic [31:0] addr;
    logic [31:0] inst_addr;
  } upd_t;

  upd_t                 mem [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr;
  logic [P_DEPTH_N-1:0] rd_ptr;
  logic [P_DEPTH_N:0]   count;
  logic                 rr;
  logic                 full;
  logic                 empty;
  logic                 grant0;
  logic                 grant1;
  logic                 grant;
  logic                 push;
  logic                 pop;
  logic                 bypass;
  upd_t                 grant_data;
  upd_t                 head;

  always_comb begin
    full       = (count == (P_DEPTH_N+1)'(P_DEPTH));
    empty      = (count == '0);
    // Full is the registered occupancy, so a same-cycle pop never frees a slot for a push.
    grant0     = !iFLUSH && !full && iREQ0_VALID && (!iREQ1_VALID || !rr);
    grant1     = !iFLUSH && !full && iREQ1_VALID && (!iREQ0_VALID ||  rr);
    grant      = grant0 || grant1;
    grant_data = grant1 ? {iREQ1_HIT, iREQ1_ADDR, iREQ1_INST_ADDR}
                        : {iREQ0_HIT, iREQ0_ADDR, iREQ0_INST_ADDR};
    pop        = !empty && !iHOLD && !iFLUSH;
`ifdef MIST1032ISA_BRANCH_UPDATE_BYPASS_EN
    bypass     = grant && empty && !iHOLD && !iFLUSH;
`else
    bypass     = 1'b0;
`endif
    push       = grant && !bypass;
    head       = mem[rd_ptr];
  end

  always_ff @(posedge iCLOCK) begin
    if (push) mem[wr_ptr] <= grant_data;
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rr              <= 1'b0;
      oJUMP_STB       <= 1'b0;
      oJUMP_HIT       <= 1'b0;
      oJUMP_ADDR      <= '0;
      oJUMP_INST_ADDR <= '0;
    end else if (iFLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr        <= 1'b0;
      oJUMP_STB <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Point at the requester that lost (or was not granted) this cycle.
      if (grant) rr <= grant0;
      oJUMP_STB <= pop || bypass;
      if (pop) begin
        oJUMP_HIT       <= head.hit;
        oJUMP_ADDR      <= head.addr;
        oJUMP_INST_ADDR <= head.inst_addr;
      end else if (bypass) begin
        oJUMP_HIT       <= grant_data.hit;
        oJUMP_ADDR      <= grant_data.addr;
        oJUMP_INST_ADDR <= grant_data.inst_addr;
      end
    end
  end

  assign oREQ0_READY = grant0;
  assign oREQ1_READY = grant1;
  assign oCOUNT      = count;
  assign oEMPTY      = empty;
  assign oFULL       = full;

endmodule

// File: tb/tb_branch_update_arbiter.sv
// Scoreboard bench for branch_update_arbiter: stimulus queues expected updates, a negedge monitor checks strobes.
module tb_branch_update_arbiter;

  typedef struct packed {
    logic        hit;
    logic [31:0] addr;
    logic [31:0] inst;
  } upd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic        v0 = 1'b0, h0 = 1'b0, v1 = 1'b0, h1 = 1'b0;
  logic [31:0] a0 = '0, i0 = '0, a1 = '0, i1 = '0;
  logic        r0, r1, stb, jhit, empty, full;
  logic [31:0] jaddr, jinst;
  logic [2:0]  count;

  upd_t sb[$];
  upd_t mon_exp;
  int   tests = 0;
  int   fails = 0;

  branch_update_arbiter #(.P_DEPTH(4), .P_DEPTH_N(2)) dut (
    .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush),
    .iREQ0_VALID(v0), .iREQ0_HIT(h0), .iREQ0_ADDR(a0), .iREQ0_INST_ADDR(i0), .oREQ0_READY(r0),
    .iREQ1_VALID(v1), .iREQ1_HIT(h1), .iREQ1_ADDR(a1), .iREQ1_INST_ADDR(i1), .oREQ1_READY(r1),
    .iHOLD(hold), .oJUMP_STB(stb), .oJUMP_HIT(jhit), .oJUMP_ADDR(jaddr),
    .oJUMP_INST_ADDR(jinst), .oCOUNT(count), .oEMPTY(empty), .oFULL(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic upd_t mk(input logic h, input logic [31:0] a, input logic [31:0] i);
    return {h, a, i};
  endfunction

  // Monitor: every strobe must match the oldest outstanding expected update.
  always @(negedge clk) begin
    if (!rst && stb === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: got strobe %0h/%0h/%0h, expected none", jhit, jaddr, jinst);
      end else begin
        mon_exp = sb.pop_front();
        check("strobe_payload", {jhit, jaddr, jinst}, mon_exp);
      end
    end
  end

  // One cycle of stimulus; er0/er1 are the hand-computed READY values for that cycle.
  task automatic drive(input logic vv0, input upd_t p0, input logic vv1, input upd_t p1,
                       input logic hh, input logic ff, input logic er0, input logic er1);
    v0 = vv0; {h0, a0, i0} = p0;
    v1 = vv1; {h1, a1, i1} = p1;
    hold = hh; flush = ff;
    @(negedge clk);
    if (vv0) check("ready0", r0, er0);
    if (vv1) check("ready1", r1, er1);
    if (er0) sb.push_back(p0);
    if (er1) sb.push_back(p1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic hh);
    repeat (n) drive(1'b0, '0, 1'b0, '0, hh, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    upd_t ua0, ua1, ua2, ub0, ub1, p4, f1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_stb",   stb,   0);
    check("rst_hit",   jhit,  0);
    check("rst_addr",  jaddr, 0);
    check("rst_inst",  jinst, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full",  full,  0);

    // Single update latency.
    drive(1'b1, mk(1'b1, 32'h100, 32'h40), 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef MIST1032ISA_BRANCH_UPDATE_BYPASS_EN
    check("lat_t1_stb",   stb,   1);
    check("lat_t1_addr",  jaddr, 32'h100);
    check("lat_t1_count", count, 0);
    idle(1, 1'b0);
    check("lat_t2_stb",   stb,   0);
`else
    check("lat_t1_stb",   stb,   0);
    check("lat_t1_count", count, 1);
    idle(1, 1'b0);
    check("lat_t2_stb",   stb,   1);
    check("lat_t2_addr",  jaddr, 32'h100);
`endif
    check("lat_count_end", count, 0);

    // Flush to bring rr back to pipe 0, then round-robin with both valid.
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    ua0 = mk(1'b0, 32'h200, 32'h80);
    ua1 = mk(1'b1, 32'h204, 32'h84);
    ua2 = mk(1'b0, 32'h208, 32'h88);
    ub0 = mk(1'b1, 32'h300, 32'hC0);
    ub1 = mk(1'b0, 32'h304, 32'hC4);
    drive(1'b1, ua0, 1'b1, ub0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, ua1, 1'b1, ub0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, ua1, 1'b1, ub1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, ua2, 1'b1, ub1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, ua2, 1'b0, '0,  1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    check("rr_count_end", count, 0);

    // Fill under hold; fifth refused while full, accepted once a pop frees a slot.
    for (int k = 0; k < 4; k++)
      drive(1'b1, mk(k[0], 32'h400 + 32'(4*k), 32'h100 + 32'(4*k)), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("fill_full",  full,  1);
    check("fill_count", count, 4);
    p4 = mk(1'b1, 32'h410, 32'h110);
    drive(1'b1, p4, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, p4, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill_pop_count", count, 3);
    check("fill_pop_full",  full,  0);
    drive(1'b1, p4, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fill_pushpop_count", count, 3);
    idle(5, 1'b0);
    check("fill_drained_count", count, 0);
    check("fill_drained_empty", empty, 1);

    // Push and pop in the same cycle at occupancy 2.
    drive(1'b1, mk(1'b0, 32'h600, 32'h180), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, mk(1'b1, 32'h604, 32'h184), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pp_count_before", count, 2);
    drive(1'b1, mk(1'b0, 32'h608, 32'h188), 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pp_count_after", count, 2);
    idle(4, 1'b0);

    // Flush with three queued and pipe 1 requesting.
    for (int k = 0; k < 3; k++)
      drive(1'b1, mk(1'b1, 32'h700 + 32'(4*k), 32'h1C0 + 32'(4*k)), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("flush_count_before", count, 3);
    f1 = mk(1'b1, 32'h800, 32'h200);
    drive(1'b0, '0, 1'b1, f1, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.delete();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_stb",   stb,   0);
    drive(1'b0, '0, 1'b1, f1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);

    // Asynchronous reset with two queued and a strobe in flight.
    for (int k = 0; k < 3; k++)
      drive(1'b1, mk(1'b1, 32'h500 + 32'(4*k), 32'h140 + 32'(4*k)), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    hold = 1'b1;
    check("arst_pre_stb",   stb,   1);
    check("arst_pre_count", count, 2);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_stb",   stb,   0);
    check("arst_hit",   jhit,  0);
    check("arst_addr",  jaddr, 0);
    check("arst_inst",  jinst, 0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full",  full,  0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(3, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
